mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
Multi-cycle sequencer wrapping the combinational radix-4 Booth multiplier array (booth_2_pair) in the ALU multiply path.
- Registers operands and holds them stable for a programmable settle window (multicycle path).
- Captures the 2*DATA_WIDTH product into HI/LO result registers.
- Presents the result on a valid/ready response handshake to the control unit.
- Adds unsigned mode, overflow detect and flush.

Parameters:
- DATA_WIDTH, 32, operand width; must be even.
- SETTLE_CYCLES, 2, cycles operands are held before product capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of any in-flight operation
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_signed  in  1  1 = two's-complement operands, 0 = unsigned
- op_a  in  DATA_WIDTH  multiplicand
- op_b  in  DATA_WIDTH  multiplier
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_hi  out  DATA_WIDTH  product[2*DATA_WIDTH-1:DATA_WIDTH]
- rsp_lo  out  DATA_WIDTH  product[DATA_WIDTH-1:0]
- rsp_ovf  out  1  product does not fit in DATA_WIDTH bits
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, counter 0, operand regs 0, rsp_hi/rsp_lo/rsp_ovf 0, rsp_valid 0, busy 0. req_ready is 0 while reset is high.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op_a, op_b and req_signed, load counter with SETTLE_CYCLES-1, then go to SETTLE.
- Operand extension (combinational, from the latched regs) to DATA_WIDTH+2 bits:
  - sign-extend when signed, zero-extend when unsigned.
  - The array is instantiated at width DATA_WIDTH+2 (stays even); only the low 2*DATA_WIDTH bits of its product are used.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0: capture the product into rsp_hi/rsp_lo, compute rsp_ovf, and go to DONE.
- rsp_ovf:
  - Signed: hi != replication of lo[MSB].
  - Unsigned: hi != 0.
- Latency: accept in cycle 0 → SETTLE occupies cycles 1..SETTLE_CYCLES → rsp_valid=1 from cycle SETTLE_CYCLES+1 (3 cycles at default).
- DONE:
  - rsp_valid=1; rsp_hi/rsp_lo/rsp_ovf held stable until rsp_ready.
  - On rsp_ready: if req_valid in the same cycle, accept the new request and go directly to SETTLE; otherwise go to IDLE.
  - req_ready = rsp_ready in DONE.
- SETTLE never asserts req_ready; requests are back-pressured.
- Operand regs change only on accept; op_a/op_b changes during SETTLE/DONE have no effect.
- flush:
  - Highest priority after reset. Next state is IDLE, rsp_valid drops the next cycle, and any pending capture is discarded.
  - req_ready is forced 0 in a flush cycle, so no accept occurs.
  - rsp_hi/rsp_lo retain their last values.
- Reset mid-operation: identical to flush, plus all registers are cleared.
- Held rsp_valid: no timeout; DONE persists indefinitely without rsp_ready.

Decomposition:
- Shared ALU package holds:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2);
  - MUL_EXT_WIDTH = DATA_WIDTH+2.
- One sub-module: the existing booth_2_pair array instantiated as the datapath; no new sub-module.
- Extension and overflow logic stay inline.

Test Plan:
1. Signed, op_a=0xFFFFFFFD (-3), op_b=7 → rsp_hi=0xFFFFFFFF, rsp_lo=0xFFFFFFEB, rsp_ovf=0; rsp_valid first high exactly 3 cycles after accept.
2. Unsigned, 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, ovf=1. Same operands signed → hi=0, lo=1, ovf=0.
3. Signed, 0x80000000×0x80000000 → hi=0x40000000, lo=0, ovf=1. Signed 0x80000000×1 → hi=0xFFFFFFFF, lo=0x80000000, ovf=0.
4. Back-pressure: hold rsp_ready=0 for 5 cycles and toggle op_a during DONE → outputs stable, req_ready=0. Then rsp_ready=1 with req_valid=1 (5×6) → accepted the same cycle; next result 30 with no IDLE cycle in between.
5. flush in cycle 1 of SETTLE → rsp_valid never rises, IDLE the next cycle, and a following request completes normally. A flush coincident with req_valid in IDLE → not accepted.
6. Reset asserted in DONE → the next cycle shows rsp_valid=0, rsp_hi=rsp_lo=0, busy=0, and req_ready=1 once reset is released.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequenced ALU multiply path: FSM encoding and
// the width of the operands presented to the Booth array.
package mul_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int DATA_WIDTH_DEFAULT = 32;

    // Two guard bits make signed and unsigned operands both exact signed values
    // and keep the array width even.
    function automatic int mul_ext_width(input int data_width);
        return data_width + 2;
    endfunction

    localparam int MUL_EXT_WIDTH = mul_ext_width(DATA_WIDTH_DEFAULT);

endpackage

// File: rtl/mul_seq_ctrl_booth_2_pair.sv
// Combinational radix-4 Booth multiplier array: signed WIDTH x WIDTH -> 2*WIDTH.
// Driven from registered operands, so it is timed as a multicycle path.
module booth_2_pair #(
    parameter int WIDTH = 34
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     b_pad;
    logic [2:0]         triplet;

    always_comb begin
        a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
        b_pad   = {b, 1'b0};
        acc     = '0;
        pp      = '0;
        triplet = '0;
        // Each overlapping bit triplet of b selects 0, +-a or +-2a, weighted by 4^i.
        for (int i = 0; i < WIDTH / 2; i++) begin
            triplet = b_pad[2*i +: 3];
            case (triplet)
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext << 1;
                3'b100:         pp = -(a_ext << 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        product = acc;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle sequencer around the Booth array: registers operands, waits a
// settle window, captures HI/LO plus overflow and returns them on valid/ready.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_hi,
    output logic [DATA_WIDTH-1:0] rsp_lo,
    output logic                  rsp_ovf,
    output logic                  busy
);

    localparam int         EXT_W       = mul_ext_width(DATA_WIDTH);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]            state;
    logic [3:0]            settle_cnt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  signed_q;
    logic                  accept;

    logic [EXT_W-1:0]        a_ext;
    logic [EXT_W-1:0]        b_ext;
    logic [2*EXT_W-1:0]      prod_full;
    logic [DATA_WIDTH-1:0]   prod_hi;
    logic [DATA_WIDTH-1:0]   prod_lo;
    logic                    prod_ovf;
    logic                    unused_prod_top;

    assign a_ext = signed_q ? {{2{a_q[DATA_WIDTH-1]}}, a_q} : {2'b00, a_q};
    assign b_ext = signed_q ? {{2{b_q[DATA_WIDTH-1]}}, b_q} : {2'b00, b_q};

    booth_2_pair #(
        .WIDTH (EXT_W)
    ) u_booth (
        .a       (a_ext),
        .b       (b_ext),
        .product (prod_full)
    );

    assign prod_hi         = prod_full[2*DATA_WIDTH-1:DATA_WIDTH];
    assign prod_lo         = prod_full[DATA_WIDTH-1:0];
    assign unused_prod_top = ^prod_full[2*EXT_W-1:2*DATA_WIDTH];

    // Signed results fit when HI is pure sign extension of LO; unsigned when HI is zero.
    assign prod_ovf = signed_q ? (prod_hi != {DATA_WIDTH{prod_lo[DATA_WIDTH-1]}})
                               : (prod_hi != '0);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and rsp_* stay stable while
    // rsp_valid is high until the edge where rsp_ready completes the transfer.
    always_comb begin
        req_ready = 1'b0;
        if (!reset && !flush) begin
            case (state)
                ST_IDLE: req_ready = 1'b1;
                ST_DONE: req_ready = rsp_ready;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            rsp_hi     <= '0;
            rsp_lo     <= '0;
            rsp_ovf    <= 1'b0;
        end else if (flush) begin
            // Abandon any capture in flight; the last result stays visible.
            state <= ST_IDLE;
        end else begin
            if (accept) begin
                a_q        <= op_a;
                b_q        <= op_b;
                signed_q   <= req_signed;
                settle_cnt <= SETTLE_INIT;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_hi  <= prod_hi;
                        rsp_lo  <= prod_lo;
                        rsp_ovf <= prod_ovf;
                        state   <= ST_DONE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= accept ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
